// File: rtl/seq_mac_multiplier.sv
// rtl/seq_mac_multiplier.sv - sequential shift-add multiplier with early exit and accumulator
module seq_mac_multiplier #(
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int ACC_W = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic                 accumulate,
  input  logic                 clear_acc,
  input  logic [A_W-1:0]       multiplicand,
  input  logic [B_W-1:0]       multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [A_W+B_W-1:0]   product,
  output logic [ACC_W-1:0]     acc,
  output logic                 overflow
);

  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = $clog2(B_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(B_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(B_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FINISH
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             step;
  logic             finish;

  logic [P_W-1:0]   acc_reg;
  logic [P_W-1:0]   mcand_reg;
  logic [B_W-1:0]   mreg;
  logic [CNT_W-1:0] count;
  logic             signed_q;
  logic             accum_q;

  logic [ACC_W-1:0] ext;
  logic [ACC_W:0]   add_full;
  logic             add_ovf;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; CALC exits once no set multiplier bits remain
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if ((mreg == '0) || (count == CNT_MAX)) begin
          state_nxt = S_FINISH;
        end else begin
          step = 1'b1;
        end
      end
      S_FINISH: begin
        finish    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Accumulator add and overflow detection for the finishing result
  always_comb begin
    ext      = signed_q ? ACC_W'($signed(acc_reg)) : ACC_W'(acc_reg);
    add_full = {1'b0, acc} + {1'b0, ext};
    if (signed_q) begin
      add_ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (add_full[ACC_W-1] != acc[ACC_W-1]);
    end else begin
      add_ovf = add_full[ACC_W];
    end
  end

  // Datapath: operand capture, shift-add steps, result and accumulator update
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg   <= '0;
      mcand_reg <= '0;
      mreg      <= '0;
      count     <= '0;
      signed_q  <= 1'b0;
      accum_q   <= 1'b0;
      product   <= '0;
      acc       <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        acc_reg   <= '0;
        mcand_reg <= signed_mode ? P_W'($signed(multiplicand)) : P_W'(multiplicand);
        mreg      <= multiplier;
        count     <= '0;
        signed_q  <= signed_mode;
        accum_q   <= accumulate;
      end
      if (step) begin
        if (mreg[0]) begin
          // The top multiplier bit carries negative weight in two's complement
          if (signed_q && (count == CNT_LAST)) begin
            acc_reg <= acc_reg - mcand_reg;
          end else begin
            acc_reg <= acc_reg + mcand_reg;
          end
        end
        mcand_reg <= mcand_reg << 1;
        mreg      <= mreg >> 1;
        count     <= count + CNT_W'(1);
      end
      if (finish) begin
        product <= acc_reg;
        if (accum_q) begin
          acc      <= add_full[ACC_W-1:0];
          overflow <= overflow | add_ovf;
        end else begin
          acc <= ext;
        end
      end
      // Clear takes precedence over a coincident accumulator update
      if (clear_acc) begin
        acc      <= '0;
        overflow <= 1'b0;
      end
    end
  end

endmodule
